// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker flush interface: control/status encodings and agent states.
// Status COMPLETED is all-ones so the controller can AND-reduce status bits across stages.
package mpt_pkg;

  typedef enum logic [1:0] {
    MPT_FLUSH_NONE    = 2'b00,
    MPT_FLUSH_SPEC    = 2'b01,
    MPT_FLUSH_ALL     = 2'b10,
    MPT_FLUSH_ALL_ALT = 2'b11
  } mptw_flush_ctrl_e;

  typedef enum logic [1:0] {
    MPT_FLUSHED_NONE      = 2'b00,
    MPT_FLUSHED_PENDING   = 2'b01,
    MPT_FLUSHED_COMPLETED = 2'b11
  } mptw_flush_status_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_DRAIN = 2'b01,
    S_DONE  = 2'b10
  } mptw_agent_state_e;

  // Status is a pure function of the state being entered, which makes it registered.
  function automatic mptw_flush_status_e status_of(mptw_agent_state_e s);
    case (s)
      S_DRAIN: status_of = MPT_FLUSHED_PENDING;
      S_DONE:  status_of = MPT_FLUSHED_COMPLETED;
      default: status_of = MPT_FLUSHED_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mptw_stage_flush_agent.sv
// Stage flush responder with a tagged in-flight FIFO; registered, no fall-through (1 cycle).
// Any nonzero flush command drops both ready and valid, so a flush always beats a transfer.
module mptw_stage_flush_agent
  import mpt_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               flush_ctrl_i,
  output logic [1:0]               flush_status_o,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  input  logic                     in_spec_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic                     out_spec_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mptw_agent_state_e  state_q, state_d;
  mptw_flush_status_e status_q;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d, tail_m1;
  logic [CW-1:0]      count_q, count_d;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]      spec_mem;

  logic ctrl_none, ctrl_spec, ctrl_all;
  logic not_empty, not_full, push, pop;

  // 2'b11 folds into ALL by looking only at the upper bit.
  assign ctrl_none = (flush_ctrl_i == MPT_FLUSH_NONE);
  assign ctrl_spec = (flush_ctrl_i == MPT_FLUSH_SPEC);
  assign ctrl_all  = flush_ctrl_i[1];

  assign not_empty = (count_q != '0);
  assign not_full  = (count_q < CW'(DEPTH));
  assign tail_m1   = tail_q - PW'(1);

  assign in_ready_o  = (state_q == S_RUN) && ctrl_none && not_full;
  assign out_valid_o = (state_q == S_RUN) && ctrl_none && not_empty;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  assign out_data_o     = not_empty ? data_mem[head_q] : '0;
  assign out_spec_o     = not_empty ? spec_mem[head_q] : 1'b0;
  assign count_o        = count_q;
  assign busy_o         = not_empty || (state_q != S_RUN);
  assign flush_status_o = status_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (state_q)
      S_RUN: begin
        if (ctrl_all) begin
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
          state_d = S_DONE;
        end else if (ctrl_spec) begin
          state_d = S_DRAIN;
        end else begin
          if (push) tail_d = tail_q + PW'(1);
          if (pop)  head_d = head_q + PW'(1);
          count_d = count_q + CW'(push) - CW'(pop);
        end
      end
      S_DRAIN: begin
        // Peel spec entries off the young end only; the first non-spec entry ends the drain.
        if (ctrl_all) begin
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
          state_d = S_DONE;
        end else if (not_empty && spec_mem[tail_m1]) begin
          tail_d  = tail_m1;
          count_d = count_q - CW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ctrl_all) begin
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end else if (ctrl_none) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_RUN;
      status_q <= MPT_FLUSHED_NONE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_of(state_d);
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      data_mem[tail_q] <= in_data_i;
      spec_mem[tail_q] <= in_spec_i;
    end
  end

endmodule
